// File: rtl/enable_gated_wr_buffer.sv
// enable_gated_wr_buffer: synchronous FIFO that stores a write only when both
// write and enable are high. A write with enable low is never stored. It sets a
// sticky illegal_wr flag and bumps a saturating violation counter.
module enable_gated_wr_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ERR_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       write,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       read,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       illegal_wr,
    output logic                       overflow,
    output logic [ERR_W-1:0]           err_count,
    input  logic                       clr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_illegal;
    logic              r_overflow;
    logic [ERR_W-1:0]  r_err_cnt;

    logic              w_full;
    logic              w_empty;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_illegal;
    logic              w_ovf;
    logic [CW-1:0]     w_count_nxt;
    logic [ERR_W-1:0]  w_err_nxt;

    // Status derived only from registered occupancy, so there is no input-to-status path.
    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_empty = (r_count == '0);
    end

    // Handshake decode: a read frees a slot, so a write on full is accepted alongside it.
    always_comb begin
        w_rd_acc  = read & ~w_empty;
        w_wr_acc  = write & enable & (~w_full | w_rd_acc);
        w_illegal = write & ~enable;
        w_ovf     = write & enable & w_full & ~w_rd_acc;
    end

    // Next occupancy and next violation count; clr_err loses to a same-cycle violation.
    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - CW'(1);
        end

        w_err_nxt = r_err_cnt;
        if (clr_err) begin
            w_err_nxt = w_illegal ? ERR_W'(1) : '0;
        end else if (w_illegal && (r_err_cnt != {ERR_W{1'b1}})) begin
            w_err_nxt = r_err_cnt + ERR_W'(1);
        end
    end

    // Storage array, deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    // Pointers, occupancy, read data and error state with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_illegal  <= 1'b0;
            r_overflow <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_count    <= w_count_nxt;
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rptr];
                r_rptr    <= r_rptr + AW'(1);
            end
            r_illegal  <= w_illegal | (r_illegal & ~clr_err);
            r_overflow <= w_ovf | (r_overflow & ~clr_err);
            r_err_cnt  <= w_err_nxt;
        end
    end

    // Output drive.
    always_comb begin
        rd_data    = r_rd_data;
        rd_valid   = r_rd_valid;
        full       = w_full;
        empty      = w_empty;
        count      = r_count;
        illegal_wr = r_illegal;
        overflow   = r_overflow;
        err_count  = r_err_cnt;
    end

endmodule

// File: tb/tb_enable_gated_wr_buffer.sv
// Directed bench for enable_gated_wr_buffer. A second instance with a 2-bit
// violation counter shares the stimulus so saturation can be observed.
module tb_enable_gated_wr_buffer;

    logic       clk = 1'b0;
    logic       rst_n, enable, write, read, clr_err;
    logic [7:0] wr_data;

    logic [7:0] rd_data;
    logic       rd_valid, full, empty, illegal_wr, overflow;
    logic [3:0] count;
    logic [7:0] err_count;

    logic [7:0] s_rd_data;
    logic       s_rd_valid, s_full, s_empty, s_illegal_wr, s_overflow;
    logic [3:0] s_count;
    logic [1:0] s_err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enable_gated_wr_buffer #(.DATA_W(8), .DEPTH(8), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .write(write), .wr_data(wr_data),
        .read(read), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .count(count), .illegal_wr(illegal_wr), .overflow(overflow),
        .err_count(err_count), .clr_err(clr_err)
    );

    enable_gated_wr_buffer #(.DATA_W(8), .DEPTH(8), .ERR_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .enable(enable), .write(write), .wr_data(wr_data),
        .read(read), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full),
        .empty(s_empty), .count(s_count), .illegal_wr(s_illegal_wr),
        .overflow(s_overflow), .err_count(s_err_count), .clr_err(clr_err)
    );

    // Apply the given inputs for one clock and sample #1 after the edge.
    task automatic step(input logic w, input logic en, input logic [7:0] d,
                        input logic r, input logic clr);
        write = w; enable = en; wr_data = d; read = r; clr_err = clr;
        @(posedge clk);
        #1;
        write = 1'b0; enable = 1'b0; read = 1'b0; clr_err = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; write = 1'b0; read = 1'b0; clr_err = 1'b0;
        wr_data = '0;
        #2;
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_illegal", 32'(illegal_wr), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_err_count", 32'(err_count), 32'h0);
        rst_n = 1'b1;

        // Basic write then read.
        step(1, 1, 8'hA1, 0, 0);
        step(1, 1, 8'hA2, 0, 0);
        step(1, 1, 8'hA3, 0, 0);
        chk("basic_count3", 32'(count), 32'h3);
        chk("basic_empty0", 32'(empty), 32'h0);
        step(0, 0, 8'h00, 1, 0);
        chk("basic_rd0", 32'(rd_data), 32'hA1);
        chk("basic_v0", 32'(rd_valid), 32'h1);
        step(0, 0, 8'h00, 1, 0);
        chk("basic_rd1", 32'(rd_data), 32'hA2);
        chk("basic_v1", 32'(rd_valid), 32'h1);
        step(0, 0, 8'h00, 1, 0);
        chk("basic_rd2", 32'(rd_data), 32'hA3);
        chk("basic_v2", 32'(rd_valid), 32'h1);
        chk("basic_count0", 32'(count), 32'h0);
        chk("basic_empty1", 32'(empty), 32'h1);
        step(0, 0, 8'h00, 1, 0);
        chk("rd_empty_valid", 32'(rd_valid), 32'h0);
        chk("rd_empty_hold", 32'(rd_data), 32'hA3);
        step(0, 1, 8'h55, 0, 0);
        chk("en_only_count", 32'(count), 32'h0);

        // Illegal writes with enable low.
        for (int i = 0; i < 4; i++) step(1, 0, 8'hBB, 0, 0);
        chk("ill_count", 32'(count), 32'h0);
        chk("ill_flag", 32'(illegal_wr), 32'h1);
        chk("ill_err4", 32'(err_count), 32'h4);
        chk("ill_small_sat", 32'(s_err_count), 32'h3);
        step(0, 0, 8'h00, 0, 1);
        chk("clr_flag", 32'(illegal_wr), 32'h0);
        chk("clr_err", 32'(err_count), 32'h0);

        // Fill, overflow, read-on-full, simultaneous write+read on full.
        for (int i = 0; i < 8; i++) step(1, 1, 8'(8'h10 + i), 0, 0);
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_count", 32'(count), 32'h8);
        chk("fill_ovf0", 32'(overflow), 32'h0);
        step(1, 1, 8'hEE, 0, 0);
        chk("ovf_flag", 32'(overflow), 32'h1);
        chk("ovf_count", 32'(count), 32'h8);
        step(0, 0, 8'h00, 1, 0);
        chk("ovf_first", 32'(rd_data), 32'h10);
        chk("ovf_count7", 32'(count), 32'h7);
        step(1, 1, 8'h20, 0, 1);
        chk("refill_full", 32'(full), 32'h1);
        chk("refill_ovf_clr", 32'(overflow), 32'h0);
        step(1, 1, 8'h21, 1, 0);
        chk("wr_rd_full_data", 32'(rd_data), 32'h11);
        chk("wr_rd_full_count", 32'(count), 32'h8);
        chk("wr_rd_full_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 8'h00, 1, 0);
            chk("drain", 32'(rd_data), (i < 6) ? 32'(8'h12 + i) : 32'(8'h20 + i - 6));
        end
        chk("drain_empty", 32'(empty), 32'h1);

        // Alternating write/read across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'(8'h40 + i), 0, 0);
            chk("alt_count1", 32'(count), 32'h1);
            step(0, 0, 8'h00, 1, 0);
            chk("alt_data", 32'(rd_data), 32'(8'h40 + i));
            chk("alt_count0", 32'(count), 32'h0);
        end

        // Write and read together on empty: write lands, read ignored.
        step(1, 1, 8'h77, 1, 0);
        chk("wr_rd_empty_valid", 32'(rd_valid), 32'h0);
        chk("wr_rd_empty_count", 32'(count), 32'h1);
        step(0, 0, 8'h00, 1, 0);
        chk("wr_rd_empty_data", 32'(rd_data), 32'h77);

        // Saturation on the 2-bit counter, then clear racing a new violation.
        for (int i = 0; i < 5; i++) step(1, 0, 8'hCC, 0, 0);
        chk("sat_small", 32'(s_err_count), 32'h3);
        chk("sat_big", 32'(err_count), 32'h5);
        step(1, 0, 8'hCC, 0, 1);
        chk("clr_race_small", 32'(s_err_count), 32'h1);
        chk("clr_race_big", 32'(err_count), 32'h1);
        chk("clr_race_flag", 32'(illegal_wr), 32'h1);
        step(0, 0, 8'h00, 0, 1);

        // Reset mid-operation.
        for (int i = 0; i < 5; i++) step(1, 1, 8'(8'h90 + i), 0, 0);
        step(1, 0, 8'hDD, 0, 0);
        chk("pre_rst_count", 32'(count), 32'h5);
        rst_n = 1'b0;
        step(0, 0, 8'h00, 0, 0);
        rst_n = 1'b1;
        chk("mid_rst_count", 32'(count), 32'h0);
        chk("mid_rst_empty", 32'(empty), 32'h1);
        chk("mid_rst_illegal", 32'(illegal_wr), 32'h0);
        chk("mid_rst_err", 32'(err_count), 32'h0);
        chk("mid_rst_rd_data", 32'(rd_data), 32'h0);
        step(0, 0, 8'h00, 1, 0);
        chk("post_rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("post_rst_empty", 32'(empty), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
